systolic_pe: RTL and testbench

//   Processing element consuming the q outputs of the row (A) and column (B) skew

---
 rtl/systolic_pe.sv | 92 +++++++++
 tb/tb_systolic_pe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pe
// Brief    : Systolic multiply-accumulate PE. A/B pass-through, 2-stage
//            signed MAC, dot product of K pairs latched into Cout with done.
// Revision : 1.0
// ============================================================================
module systolic_pe #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 24,
    parameter int K       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [BITS_AB-1:0] Ain,
    input  logic [BITS_AB-1:0] Bin,
    output logic [BITS_AB-1:0] Aout,
    output logic [BITS_AB-1:0] Bout,
    output logic [BITS_C-1:0]  Cout,
    output logic               done
);

    localparam int              c_pw    = 2 * BITS_AB;
    localparam int              c_cnt_w = (K > 1) ? $clog2(K) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(K - 1);

    logic signed [c_pw-1:0]   w_mul;
    logic signed [BITS_C-1:0] w_p;
    logic        [BITS_C-1:0] w_sum;

    logic signed [c_pw-1:0]   r_prod;
    logic                     r_prod_v;
    logic        [BITS_C-1:0] r_acc;
    logic        [c_cnt_w-1:0] r_cnt;

    assign w_mul = c_pw'($signed(Ain)) * c_pw'($signed(Bin));
    assign w_p   = BITS_C'(r_prod);
    assign w_sum = r_acc + w_p;

    // Stage 1: operand pass-through and product register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Aout   <= '0;
            Bout   <= '0;
            r_prod <= '0;
        end else if (en) begin
            Aout   <= Ain;
            Bout   <= Bin;
            r_prod <= w_mul;
        end
    end

    // A pair sampled together with clr never reaches the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_v <= 1'b0;
        end else begin
            r_prod_v <= en && !clr;
        end
    end

    // Stage 2: accumulate, and publish on the K-th product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            Cout  <= '0;
            done  <= 1'b0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
            done  <= 1'b0;
        end else if (r_prod_v) begin
            if (r_cnt == c_last) begin
                Cout  <= w_sum;
                done  <= 1'b1;
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + c_cnt_w'(1);
                done  <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_pe
// Brief    : Self-checking bench for systolic_pe (default, 16-bit Cout, K=1).
// Revision : 1.0
// ============================================================================
module tb_systolic_pe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] Ain = '0;
    logic [7:0] Bin = '0;

    logic [7:0]  aout, bout, aout_w, bout_w, aout_1, bout_1;
    logic [23:0] cout, cout_1;
    logic [15:0] cout_w;
    logic        done, done_w, done_1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: sampled-but-unaccumulated product plus queue of the
    // products belonging to the current dot product.
    bit          m_inf_v;
    longint      m_inf;
    longint      m_q[$];
    logic [7:0]  m_a, m_b;
    logic [23:0] m_c, m_c1;
    logic [15:0] m_cw;
    logic        m_done, m_done1;

    always #5 clk = ~clk;

    systolic_pe dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .Ain(Ain), .Bin(Bin),
        .Aout(aout), .Bout(bout), .Cout(cout), .done(done)
    );

    systolic_pe #(.BITS_C(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .Ain(Ain), .Bin(Bin),
        .Aout(aout_w), .Bout(bout_w), .Cout(cout_w), .done(done_w)
    );

    systolic_pe #(.K(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .Ain(Ain), .Bin(Bin),
        .Aout(aout_1), .Bout(bout_1), .Cout(cout_1), .done(done_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint qsum();
        longint s = 0;
        foreach (m_q[i]) s += m_q[i];
        return s;
    endfunction

    task automatic model_reset();
        m_inf_v = 0; m_inf = 0; m_q.delete();
        m_a = 0; m_b = 0; m_c = 0; m_c1 = 0; m_cw = 0;
        m_done = 0; m_done1 = 0;
    endtask

    task automatic model_edge(input logic e, input logic c, input logic [7:0] a, input logic [7:0] b);
        m_done  = 0;
        m_done1 = 0;
        if (c) begin
            m_q.delete();
        end else if (m_inf_v) begin
            m_q.push_back(m_inf);
            m_c1    = 24'(m_inf);
            m_done1 = 1;
            if (m_q.size() == 8) begin
                m_c    = 24'(qsum());
                m_cw   = 16'(qsum());
                m_done = 1;
                m_q.delete();
            end
        end
        m_inf_v = e && !c;
        if (e) begin
            m_inf = longint'($signed(a)) * longint'($signed(b));
            m_a   = a;
            m_b   = b;
        end
    endtask

    task automatic check_all();
        chk("aout",   32'(aout),   32'(m_a));
        chk("bout",   32'(bout),   32'(m_b));
        chk("cout",   32'(cout),   32'(m_c));
        chk("done",   32'(done),   32'(m_done));
        chk("cout_w", 32'(cout_w), 32'(m_cw));
        chk("done_w", 32'(done_w), 32'(m_done));
        chk("aout_1", 32'(aout_1), 32'(m_a));
        chk("cout_1", 32'(cout_1), 32'(m_c1));
        chk("done_1", 32'(done_1), 32'(m_done1));
    endtask

    // Drive inputs at the falling edge, let the rising edge sample, check 1 ns later.
    task automatic step(input logic e, input logic c, input logic [7:0] a, input logic [7:0] b);
        en = e; clr = c; Ain = a; Bin = b;
        @(posedge clk);
        model_edge(e, c, a, b);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        en = 1'b1; Ain = 8'h11; Bin = 8'h22;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_aout", 32'(aout), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: basic 3x4
        step(1'b1, 1'b0, 8'd3, 8'd4);
        chk("basic_aout1", 32'(aout), 32'd3);
        chk("basic_bout1", 32'(bout), 32'd4);
        for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 8'd3, 8'd4);
        chk("basic_nodone_early", 32'(done), 32'd0);
        step(1'b0, 1'b0, 8'd0, 8'd0);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_cout", 32'(cout), 32'd96);
        step(1'b0, 1'b0, 8'd0, 8'd0);
        chk("basic_done_pulse", 32'(done), 32'd0);

        // 3: signed extremes
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h80, 8'd127);
        step(1'b0, 1'b0, 8'd0, 8'd0);
        chk("signed_cout", 32'(cout), 32'h00FE0400);
        chk("signed_done", 32'(done), 32'd1);

        // 4: en gaps then back-to-back streaming
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 8'd1, 8'(i));
            step(1'b0, 1'b0, 8'hFF, 8'hFF);
        end
        chk("gap_cout", 32'(cout), 32'd36);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'd2, 8'd2);
        step(1'b0, 1'b0, 8'd0, 8'd0);
        chk("stream_cout", 32'(cout), 32'd32);

        // 5: clr mid-run; the clr cycle also carries en
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd3, 8'd4);
        step(1'b1, 1'b1, 8'd5, 8'd6);
        chk("clr_aout", 32'(aout), 32'd5);
        chk("clr_bout", 32'(bout), 32'd6);
        for (int i = 0; i < 8; i++) begin
            chk("clr_cout_hold", 32'(cout), 32'd32);
            step(1'b1, 1'b0, 8'd3, 8'd4);
        end
        step(1'b0, 1'b0, 8'd0, 8'd0);
        chk("clr_done", 32'(done), 32'd1);
        chk("clr_cout", 32'(cout), 32'd96);

        // 6: wrap at 16 bits
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'd127, 8'd127);
        step(1'b0, 1'b0, 8'd0, 8'd0);
        chk("wrap_cout_w", 32'(cout_w), 32'h0000F808);
        chk("wrap_cout", 32'(cout), 32'h0001F808);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0),
                 8'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
